// File: rtl/grid_pkg.sv
// Shared grid geometry and display FSM state encoding for grid_display.
package grid_pkg;

    localparam int GRID_ROWS = 8;
    localparam int GRID_COLS = 8;
    localparam int GRID_BITS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } display_state_t;

    function automatic logic [GRID_ROWS-1:0] row_onehot(input logic [2:0] row);
        logic [GRID_ROWS-1:0] v;
        v = '0;
        v[row] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/row_timer.sv
// Dwell/blank cycle counter: counts 0..i_last while enabled, flags terminal count,
// wraps to 0 on terminal count, synchronous restart overrides everything.
module row_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_restart,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    assign o_tc = i_en && !i_restart && (r_count == i_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_restart) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/grid_display.sv
// 8x8 row-multiplexed LED grid driver with a one-deep pending frame buffer; frames
// swap only at the row 7 -> 0 wrap. Define GRID_DISPLAY_BLANK_EN for inter-row blanking.
module grid_display
    import grid_pkg::*;
#(
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [GRID_BITS-1:0] grid_in,
    input  logic                 grid_valid,
    output logic                 grid_ready,
    output logic [GRID_ROWS-1:0] row_sel,
    output logic [GRID_COLS-1:0] col_drive,
    output logic                 frame_done
);

    localparam logic [15:0] DWELL_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

    display_state_t       r_state;
    display_state_t       w_state_nxt;
    logic [GRID_BITS-1:0] r_pend;
    logic [GRID_BITS-1:0] r_active;
    logic                 r_pend_full;
    logic [2:0]           r_row;

    logic        w_accept;
    logic        w_tc;
    logic        w_row_adv;
    logic        w_wrap;
    logic        w_load;
    logic        w_scan;
    logic [15:0] w_last;

    assign grid_ready = !r_pend_full;
    assign w_accept   = grid_valid && grid_ready;

    // BLANK is unreachable in the default build, so the BLANK_LAST arm folds away.
    assign w_last = (r_state == BLANK) ? BLANK_LAST : DWELL_LAST;

    row_timer #(.W(16)) u_row_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_restart (r_state == IDLE),
        .i_en      (r_state != IDLE),
        .i_last    (w_last),
        .o_tc      (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_row_adv   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend_full) w_state_nxt = SCAN;
            end
            SCAN: begin
                if (w_tc) begin
`ifdef GRID_DISPLAY_BLANK_EN
                    w_state_nxt = BLANK;
`else
                    w_row_adv   = 1'b1;
`endif
                end
            end
`ifdef GRID_DISPLAY_BLANK_EN
            BLANK: begin
                if (w_tc) begin
                    w_state_nxt = SCAN;
                    w_row_adv   = 1'b1;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_wrap = w_row_adv && (r_row == 3'd7);
    assign w_load = r_pend_full && ((r_state == IDLE) || w_wrap);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_row       <= '0;
            r_pend      <= '0;
            r_active    <= '0;
            r_pend_full <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE) begin
                r_row <= '0;
            end else if (w_row_adv) begin
                r_row <= r_row + 3'd1;
            end
            if (w_load) begin
                r_active <= r_pend;
            end
            // Accept and load are exclusive: accept needs an empty pending buffer.
            if (w_accept) begin
                r_pend      <= grid_in;
                r_pend_full <= 1'b1;
            end else if (w_load) begin
                r_pend_full <= 1'b0;
            end
        end
    end

    assign w_scan     = (r_state == SCAN);
    assign row_sel    = w_scan ? row_onehot(r_row) : '0;
    assign col_drive  = w_scan ? r_active[{r_row, 3'b000} +: GRID_COLS] : '0;
    assign frame_done = w_wrap;

endmodule

// File: tb/tb_grid_display.sv
module tb_grid_display;

    localparam int CLK_DIV = 4;
    localparam int BLANK_CYCLES = 2;
`ifdef GRID_DISPLAY_BLANK_EN
    localparam int BL = BLANK_CYCLES;
`else
    localparam int BL = 0;
`endif
    localparam int ROWLEN = CLK_DIV + BL;
    localparam int FRAME  = 8 * ROWLEN;
    localparam logic [17:0] IDLE_OUT = 18'h20000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] grid_in;
    logic        grid_valid;
    logic        grid_ready;
    logic [7:0]  row_sel;
    logic [7:0]  col_drive;
    logic        frame_done;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: time since scan start, plus the two frame buffers.
    bit          m_started;
    bit          m_pend_full;
    logic [63:0] m_pend;
    logic [63:0] m_active;
    int          m_t;

    always #5 clk = ~clk;

    grid_display #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .grid_in    (grid_in),
        .grid_valid (grid_valid),
        .grid_ready (grid_ready),
        .row_sel    (row_sel),
        .col_drive  (col_drive),
        .frame_done (frame_done)
    );

    function automatic logic [17:0] observed();
        return {grid_ready, frame_done, row_sel, col_drive};
    endfunction

    function automatic int m_row();
        return (m_t / ROWLEN) % 8;
    endfunction

    function automatic bit m_on();
        return m_started && ((m_t % ROWLEN) < CLK_DIV);
    endfunction

    function automatic logic [17:0] expected();
        logic [7:0] rs;
        logic [7:0] cd;
        logic       fd;
        rs = '0;
        cd = '0;
        if (m_on()) begin
            rs = 8'(1 << m_row());
            cd = m_active[m_row()*8 +: 8];
        end
        fd = m_started && (m_t == FRAME - 1);
        return {!m_pend_full, fd, rs, cd};
    endfunction

    task automatic model_reset();
        m_started = 0;
        m_pend_full = 0;
        m_pend = '0;
        m_active = '0;
        m_t = 0;
    endtask

    task automatic model_update(input bit v, input logic [63:0] d);
        bit acc;
        acc = v && !m_pend_full;
        if (!m_started) begin
            if (m_pend_full) begin
                m_started = 1;
                m_active = m_pend;
                m_pend_full = 0;
                m_t = 0;
            end
        end else begin
            if (m_t == FRAME - 1 && m_pend_full) begin
                m_active = m_pend;
                m_pend_full = 0;
            end
            m_t = (m_t + 1) % FRAME;
        end
        if (acc) begin
            m_pend = d;
            m_pend_full = 1;
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic drive_cycle(input bit v, input logic [63:0] d);
        grid_valid = v;
        grid_in = d;
        @(posedge clk);
        model_update(v, d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (observed() !== IDLE_OUT) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", observed(), IDLE_OUT);
        end
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 50; i++) begin
            drive_cycle(1'b0, {$urandom, $urandom});
            n_cmp++;
            if (observed() !== IDLE_OUT) begin
                n_fail++;
                $display("FAIL idle_hold cyc %0d: got %h expected %h", i, observed(), IDLE_OUT);
            end
        end
    endtask

    task automatic test_diagonal();
        int fd_cnt;
        drive_cycle(1'b1, 64'h8040201008040201);
        fd_cnt = 0;
        for (int i = 0; i < 2 * FRAME + 1; i++) begin
            drive_cycle(1'b0, '0);
            n_cmp++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL diag_model cyc %0d: got %h expected %h", i, observed(), expected());
            end
            if (row_sel != 0) begin
                n_cmp++;
                if (col_drive !== row_sel) begin
                    n_fail++;
                    $display("FAIL diag_pattern cyc %0d: got %h expected %h", i, col_drive, row_sel);
                end
            end
            if (frame_done === 1'b1) fd_cnt++;
        end
        n_cmp++;
        if (fd_cnt != 2) begin
            n_fail++;
            $display("FAIL diag_frame_done_count: got %0d expected 2", fd_cnt);
        end
    endtask

    task automatic test_midframe_load();
        int guard;
        guard = 0;
        while (!(m_on() && m_row() == 3) && guard < 2 * FRAME) begin
            drive_cycle(1'b0, '0);
            guard++;
        end
        n_cmp++;
        if (guard >= 2 * FRAME) begin
            n_fail++;
            $display("FAIL mid_wait_row3: got timeout expected row 3");
        end
        drive_cycle(1'b1, {64{1'b1}});
        n_cmp++;
        if (grid_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ready_low: got %b expected 0", grid_ready);
        end
        guard = 0;
        while (m_t != 0 && guard < 2 * FRAME) begin
            drive_cycle(1'b1, {$urandom, $urandom});
            guard++;
            n_cmp++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL mid_old_frame: got %h expected %h", observed(), expected());
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            drive_cycle(1'b0, '0);
            if (row_sel != 0) begin
                n_cmp++;
                if (col_drive !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL mid_new_frame cyc %0d: got %h expected ff", i, col_drive);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4 * FRAME; i++) begin
            drive_cycle(1'b1, {$urandom, $urandom});
            n_cmp++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL b2b cyc %0d: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * FRAME; i++) begin
            drive_cycle(($urandom_range(0, 9) == 0), {$urandom, $urandom});
            n_cmp++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_reset_midscan();
        int guard;
        guard = 0;
        while (!(m_on() && m_row() == 5) && guard < 2 * FRAME) begin
            drive_cycle(1'b0, '0);
            guard++;
        end
        n_cmp++;
        if (guard >= 2 * FRAME) begin
            n_fail++;
            $display("FAIL rst_wait_row5: got timeout expected row 5");
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (observed() !== IDLE_OUT) begin
            n_fail++;
            $display("FAIL rst_async_clear: got %h expected %h", observed(), IDLE_OUT);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0, {$urandom, $urandom});
            n_cmp++;
            if (observed() !== IDLE_OUT) begin
                n_fail++;
                $display("FAIL rst_stay_idle cyc %0d: got %h expected %h", i, observed(), IDLE_OUT);
            end
        end
        drive_cycle(1'b1, {$urandom, $urandom});
        for (int i = 0; i < FRAME + 2; i++) begin
            drive_cycle(1'b0, '0);
            n_cmp++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL rst_restart cyc %0d: got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        grid_valid = 1'b0;
        grid_in = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_diagonal();
        test_midframe_load();
        test_back_to_back();
        test_random();
        test_reset_midscan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/grid_display.md
GRID_DISPLAY -- requirements
Module: grid_display

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000, meaning clock cycles each row is driven (legal 2..65535).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, meaning inter-row blanking length (legal 1..255), used only with GRID_DISPLAY_BLANK_EN.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port grid_in  input  64  8x8 grid from the game FSM; bit 8r+c is row r, column c.
REQ-006 SHALL have port grid_valid  input  1  grid_in holds a new frame.
REQ-007 SHALL have port grid_ready  output  1  block can accept a frame this cycle.
REQ-008 SHALL have port row_sel  output  8  one-hot active-high row enable.
REQ-009 SHALL have port col_drive  output  8  active-high column data for the selected row.
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse at end of each full 8-row scan.

Function
REQ-011 SHALL accept a frame into a pending buffer on any rising edge where grid_valid and grid_ready are both 1.
REQ-012 SHALL drive grid_ready = 1 exactly when the pending buffer is empty (combinational from the pending-full flag).
REQ-013 SHALL ignore grid_in whenever grid_ready is 0; no frame is ever dropped once accepted.
REQ-014 SHALL implement states IDLE, SCAN, and BLANK (BLANK only with GRID_DISPLAY_BLANK_EN).
REQ-015 IDLE: row_sel = 0 and col_drive = 0; on the edge after pending is full, copy pending to the active buffer, clear pending, set row index 0, and enter SCAN.
REQ-016 SCAN: row_sel = 1 << row index, and col_drive = active[8*row+7 : 8*row]; a dwell counter counts 0..CLK_DIV-1.
REQ-017 At dwell count CLK_DIV-1, SHALL advance to the next row (via BLANK if enabled) and reset the dwell counter.
REQ-018 Row index SHALL wrap 7 -> 0; at that wrap edge, if pending is full, pending SHALL be copied to active and cleared; otherwise active SHALL be retained and re-scanned.
REQ-019 Frame swap SHALL occur only at the 7 -> 0 wrap, never mid-frame (no tearing).
REQ-020 frame_done SHALL be 1 for exactly the single cycle in which the row index wraps 7 -> 0 (the last dwell cycle of row 7, or the last blank cycle after row 7 when blanking is enabled).
REQ-021 Acceptance on the same edge as a swap SHALL be impossible, because grid_ready is 0 while pending is full; the accepted frame on the following free cycle goes to pending.
REQ-022 Once it has left IDLE, the block SHALL never return to IDLE except through reset.

Reset
REQ-023 While reset_n = 0: state IDLE, row_sel = 0, col_drive = 0, frame_done = 0, grid_ready = 1, pending empty, active = 0, counters = 0.
REQ-024 Reset asserted mid-scan or mid-blank SHALL clear all outputs immediately (asynchronously) and discard both buffers.

Configuration
REQ-025 With macro GRID_DISPLAY_BLANK_EN defined, each row SHALL be followed by BLANK_CYCLES cycles in BLANK with row_sel = 0 and col_drive = 0, to suppress ghosting.
REQ-026 Without GRID_DISPLAY_BLANK_EN, the BLANK state and its counter SHALL not exist, and rows SHALL switch back-to-back.

Structure
REQ-027 A shared package grid_pkg SHALL hold GRID_ROWS = 8, GRID_COLS = 8, GRID_BITS = 64, and the typedef enum logic [1:0] display_state_t {IDLE, SCAN, BLANK}.
REQ-028 The dwell/blank counter SHALL be a sub-module named row_timer, with a terminal-count output and a synchronous restart input.

Verification (CLK_DIV = 4, BLANK_CYCLES = 2)
REQ-029 Reset, then hold grid_valid = 0 for 50 cycles -> row_sel = 0, col_drive = 0, grid_ready = 1 throughout.
REQ-030 Load grid_in = 64'h8040201008040201 -> rows 0..7 each show col_drive = 8'h01 << r for 4 cycles, and frame_done pulses once per 32 cycles (no blanking).
REQ-031 Mid-frame, load 64'hFFFF...FF while row 3 is active -> grid_ready = 0 until the wrap, rows 3..7 still show the old data, and the next frame shows all 8'hFF.
REQ-032 Hold grid_valid = 1 continuously with changing data -> exactly one frame is accepted per scan, and each displayed frame matches the value sampled when grid_ready was 1.
REQ-033 Assert reset_n = 0 during row 5 -> outputs are 0 in the same cycle; after release, the block stays in IDLE until a new frame arrives.
REQ-034 With GRID_DISPLAY_BLANK_EN defined -> 2 all-zero cycles between rows, frame period 48 cycles, and frame_done at the end of the blank after row 7.
